// File: rtl/snn_video_pkg.sv
// Shared definitions for the SNN video source: pattern codes, bar palette and LFSR constants.
package snn_video_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LFSR  = 2'd3
    } pat_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a Fibonacci LFSR, expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // {r,g,b} on/off per bar; index 0 is the leftmost bar (white) through 7 (black)
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        c = BAR_RGB[idx];
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/snn_video_timing.sv
// Raster timing for the SNN video source: hold/h/v counters, run/stop FSM and timing strobes.
// Strobes are combinational from counter state; the top registers them for output alignment.
module snn_video_timing #(
    parameter int H_ACT    = 640,
    parameter int PIX_HOLD = 64,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int XW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          go,
    output logic          frame_first,
    output logic          de,
    output logic          hs_act,
    output logic          vs_act,
    output logic          pix_adv,
    output logic [XW-1:0] px_x,
    output logic [VW-1:0] py
);

    localparam int HA_CLK = H_ACT * PIX_HOLD;
    localparam int HT     = HA_CLK + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW     = (HT > 1) ? $clog2(HT) : 1;
    localparam int HOLD_W = (PIX_HOLD > 1) ? $clog2(PIX_HOLD) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q;
    logic [VW-1:0]   v_q;
    logic [HOLD_W-1:0] hold_q;
    logic [XW-1:0]   x_q;
    logic            stop_q;

    logic h_last, v_last, h_in_act, hold_last;

    assign h_last    = (int'(h_q) == HT - 1);
    assign v_last    = (int'(v_q) == VT - 1);
    assign h_in_act  = (int'(h_q) < HA_CLK);
    assign hold_last = (int'(hold_q) == PIX_HOLD - 1);

    // IDLE with en counts as the first running clock, so frame_start needs no extra cycle
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    go      = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                go = 1'b1;
                if (h_last && v_last && stop_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= (state_q == ST_RUN) && !en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            hold_q <= '0;
            x_q    <= '0;
        end else if (go) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
            if (h_in_act) begin
                if (hold_last) begin
                    hold_q <= '0;
                    x_q    <= (int'(x_q) == H_ACT - 1) ? '0 : x_q + 1'b1;
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end
    end

    assign frame_first = go && (h_q == '0) && (v_q == '0);
    assign de          = go && h_in_act && (int'(v_q) < V_ACT);
    assign hs_act      = go && (int'(h_q) >= HA_CLK + H_FP) && (int'(h_q) < HA_CLK + H_FP + H_SYNC);
    assign vs_act      = go && (int'(v_q) >= V_ACT + V_FP) && (int'(v_q) < V_ACT + V_FP + V_SYNC);
    assign pix_adv     = de && hold_last;
    assign px_x        = x_q;
    assign py          = v_q;

endmodule

// File: rtl/snn_video_src.sv
// Test-pattern video source feeding the SNN classifier; each active pixel is held PIX_HOLD clocks.
// All outputs are registered one clock after counter state; reset forces idle outputs immediately.
module snn_video_src
    import snn_video_pkg::*;
#(
    parameter int H_ACT    = 640,
    parameter int PIX_HOLD = 64,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CHK_LOG2 = 3,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] pat_sel,
    input  logic [7:0] solid_r,
    input  logic [7:0] solid_g,
    input  logic [7:0] solid_b,
    output logic       vs_out,
    output logic       hs_out,
    output logic       de_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       frame_start,
    output logic       busy
);

    localparam int VT    = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int XW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int VW    = (VT > 1) ? $clog2(VT) : 1;
    localparam int BAR_W = H_ACT / 8;

    logic          go, frame_first, de, hs_act, vs_act, pix_adv;
    logic [XW-1:0] px_x;
    logic [VW-1:0] py;

    snn_video_timing #(
        .H_ACT(H_ACT), .PIX_HOLD(PIX_HOLD),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .VW(VW)
    ) u_timing (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .go         (go),
        .frame_first(frame_first),
        .de         (de),
        .hs_act     (hs_act),
        .vs_act     (vs_act),
        .pix_adv    (pix_adv),
        .px_x       (px_x),
        .py         (py)
    );

    pat_e        pat_q, pat_cur;
    logic [23:0] solid_q, solid_cur;
    logic [15:0] lfsr_q, lfsr_cur;
    logic [2:0]  bar_idx;
    logic        chk_on;
    logic [23:0] pix;

    // Settings latched at frame start are bypassed on that same clock so the first pixel uses them
    always_comb begin
        pat_cur   = frame_first ? pat_e'(pat_sel) : pat_q;
        solid_cur = frame_first ? {solid_r, solid_g, solid_b} : solid_q;
        lfsr_cur  = frame_first ? LFSR_SEED : lfsr_q;
        bar_idx   = 3'(int'(px_x) / BAR_W);
        chk_on    = (((32'(px_x) ^ 32'(py)) >> CHK_LOG2) & 32'd1) != 32'd0;
        pix       = 24'd0;
        case (pat_cur)
            PAT_SOLID: pix = solid_cur;
            PAT_BARS:  pix = bar_colour(bar_idx);
            PAT_CHECK: pix = chk_on ? 24'hFF_FFFF : 24'd0;
            PAT_LFSR:  pix = {lfsr_cur[15:8], lfsr_cur[7:0], lfsr_cur[15:8] ^ lfsr_cur[7:0]};
            default:   pix = 24'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= PAT_SOLID;
            solid_q <= 24'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            if (frame_first) begin
                pat_q   <= pat_cur;
                solid_q <= solid_cur;
            end
            lfsr_q <= pix_adv ? lfsr_next(lfsr_cur) : lfsr_cur;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_out      <= ~SYNC_POL;
            hs_out      <= ~SYNC_POL;
            de_out      <= 1'b0;
            r_out       <= 8'd0;
            g_out       <= 8'd0;
            b_out       <= 8'd0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vs_out      <= vs_act ? SYNC_POL : ~SYNC_POL;
            hs_out      <= hs_act ? SYNC_POL : ~SYNC_POL;
            de_out      <= de;
            {r_out, g_out, b_out} <= de ? pix : 24'd0;
            frame_start <= frame_first;
            busy        <= go;
        end
    end

endmodule

// File: tb/tb_snn_video_src.sv
// Directed bench for snn_video_src on a small raster (HT=24, 8 lines, 192 clocks per frame).
module tb_snn_video_src;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] pat_sel = 2'd0;
    logic [7:0] solid_r = 8'd0, solid_g = 8'd0, solid_b = 8'd0;
    logic       vs_out, hs_out, de_out, frame_start, busy;
    logic [7:0] r_out, g_out, b_out;

    int n_cmp = 0;
    int n_bad = 0;
    int de_cnt;
    logic [15:0] m;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    snn_video_src #(
        .H_ACT(8), .PIX_HOLD(2), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CHK_LOG2(1), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .pat_sel(pat_sel),
        .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .frame_start(frame_start), .busy(busy)
    );

    wire [28:0] obs_v = {vs_out, hs_out, de_out, frame_start, busy, r_out, g_out, b_out};
    wire [23:0] obs_rgb = {r_out, g_out, b_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected output vector at clock f of a running frame with solid colour s
    function automatic logic [28:0] tmodel(input int f, input logic [23:0] s);
        int  ff, ln, h;
        bit  d;
        ff = f % 192;
        ln = ff / 24;
        h  = ff % 24;
        d  = (ln < 4) && (h < 16);
        return {(ln == 5 || ln == 6), (h >= 18 && h <= 20), d, (ff == 0), 1'b1, d ? s : 24'd0};
    endfunction

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Returns at the sample point of clock 0 (first frame_start)
    task automatic restart(input logic [1:0] p, input logic [23:0] s);
        reset_n = 1'b0;
        en      = 1'b1;
        pat_sel = p;
        {solid_r, solid_g, solid_b} = s;
        @(negedge clk);
        chk("reset_idle", 32'(obs_v), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Raster timing with solid colour over two frames
        restart(2'd0, 24'h0A141E);
        de_cnt = 0;
        for (int k = 0; k < 384; k++) begin
            chk($sformatf("timing@%0d", k), 32'(obs_v), 32'(tmodel(k, 24'h0A141E)));
            if (de_out) de_cnt++;
            @(negedge clk);
        end
        chk("de_count", 32'(de_cnt), 32'd128);

        // Colour bars on line 0
        restart(2'd1, 24'd0);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("bars@%0d", k), 32'(obs_rgb), (k < 16) ? 32'(bars[k / 2]) : 32'd0);
            @(negedge clk);
        end

        // Checker, 2-pixel squares
        restart(2'd2, 24'd0);
        for (int k = 0; k < 96; k++) begin
            int ln, h;
            ln = k / 24;
            h  = k % 24;
            chk($sformatf("check@%0d", k), 32'(obs_rgb),
                (h < 16 && ((((h / 2) >> 1) ^ (ln >> 1)) & 1) == 1) ? 32'hFFFFFF : 32'd0);
            @(negedge clk);
        end

        // LFSR noise, reseeded every frame
        restart(2'd3, 24'd0);
        m = 16'hACE1;
        for (int k = 0; k < 384; k++) begin
            int ff, ln, h;
            bit d;
            ff = k % 192;
            ln = ff / 24;
            h  = ff % 24;
            d  = (ln < 4) && (h < 16);
            if (ff == 0) m = 16'hACE1;
            if (k < 2) chk($sformatf("lfsr_first@%0d", k), 32'(obs_rgb), 32'hACE14D);
            chk($sformatf("lfsr@%0d", k), 32'(obs_rgb),
                d ? 32'({m[15:8], m[7:0], m[15:8] ^ m[7:0]}) : 32'd0);
            if (d && (h % 2) == 1) m = step(m);
            @(negedge clk);
        end

        // Stop request: frame completes then idles
        restart(2'd0, 24'h0A141E);
        for (int k = 0; k < 260; k++) begin
            chk($sformatf("stop@%0d", k), 32'(obs_v), (k < 192) ? 32'(tmodel(k, 24'h0A141E)) : 32'd0);
            if (k == 50) en = 1'b0;
            @(negedge clk);
        end

        // Stop request withdrawn before the wrap: continuous frames
        restart(2'd0, 24'h0A141E);
        for (int k = 0; k < 400; k++) begin
            chk($sformatf("resume@%0d", k), 32'(obs_v), 32'(tmodel(k, 24'h0A141E)));
            if (k == 50) en = 1'b0;
            if (k == 100) en = 1'b1;
            @(negedge clk);
        end

        // Asynchronous reset mid-active
        restart(2'd0, 24'h0A141E);
        repeat (30) @(negedge clk);
        chk("pre_reset@30", 32'(obs_v), 32'(tmodel(30, 24'h0A141E)));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 32'(obs_v), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset@0", 32'(obs_v), 32'(tmodel(0, 24'h0A141E)));

        // Solid colour change mid-frame applies from the next frame
        restart(2'd0, 24'h0A141E);
        for (int k = 0; k < 200; k++) begin
            chk($sformatf("latch@%0d", k), 32'(obs_v),
                32'(tmodel(k, (k < 192) ? 24'h0A141E : 24'h010203)));
            if (k == 40) {solid_r, solid_g, solid_b} = 24'h010203;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
